// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares the single VRAM port between display scan-out and NUM_CLIENTS
//   game-logic clients. Inside the fetch window (derived from the H/V
//   counters, one pixel early) the display owns the port. Outside it,
//   one client access at a time is served in round-robin order using a
//   req/ack handshake.
//
// Ports
//   i_clk, i_resetn        pixel clock, synchronous active-low reset
//   i_h_count, i_v_count   raster counters
//   i_disp_addr            display fetch address
//   o_disp_rdata           display read data (word at addr(h) appears at h+2)
//   i_cli_req/we/addr/wdata  per-client request bundle (packed, client i
//                          at [i*W +: W])
//   o_cli_ack              one-hot, one-cycle completion pulse
//   o_cli_rdata            client read data, valid with o_cli_ack
//   o_mem_*, i_mem_rdata   VRAM port (1-cycle synchronous read latency)
//   o_frame_start          pulse the cycle after counters read (0,0)
module vram_port_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 12,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic [15:0]                   i_h_count,
  input  logic [15:0]                   i_v_count,
  input  logic [ADDR_W-1:0]             i_disp_addr,
  output logic [DATA_W-1:0]             o_disp_rdata,
  input  logic [NUM_CLIENTS-1:0]        i_cli_req,
  input  logic [NUM_CLIENTS-1:0]        i_cli_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] i_cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] i_cli_wdata,
  output logic [NUM_CLIENTS-1:0]        o_cli_ack,
  output logic [DATA_W-1:0]             o_cli_rdata,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic                          o_mem_we,
  output logic [DATA_W-1:0]             o_mem_wdata,
  input  logic [DATA_W-1:0]             i_mem_rdata,
  output logic                          o_frame_start
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  // Window opens one count early so the registered read lands on the pixel
  localparam logic [15:0] H_WIN_LO = 16'(H_ACT_START - 1);
  localparam logic [15:0] H_WIN_HI = 16'(H_ACT_END - 1);
  localparam logic [15:0] V_WIN_LO = 16'(V_ACT_START);
  localparam logic [15:0] V_WIN_HI = 16'(V_ACT_END);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                              r_state, w_state_nxt;
  logic [IDX_W-1:0]                    r_rr_ptr, r_win, w_pick;
  logic                                w_found, w_fetch_win, w_grant;
  logic                                r_fetch_d;
  logic [DATA_W-1:0]                   r_disp_rdata;
  logic                                r_frame_start;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  w_cli_addr;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  w_cli_wdata;

  assign w_cli_addr  = i_cli_addr;
  assign w_cli_wdata = i_cli_wdata;

  function automatic logic [IDX_W-1:0] f_wrap(input logic [31:0] v);
    return IDX_W'(v % 32'(NUM_CLIENTS));
  endfunction

  assign w_fetch_win = (i_h_count >= H_WIN_LO) && (i_h_count < H_WIN_HI) &&
                       (i_v_count >= V_WIN_LO) && (i_v_count < V_WIN_HI);

  // First requester scanning upward from the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!w_found && i_cli_req[f_wrap(32'(r_rr_ptr) + 32'(k))]) begin
        w_found = 1'b1;
        w_pick  = f_wrap(32'(r_rr_ptr) + 32'(k));
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && !w_fetch_win && w_found;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      // An opened window stalls the latched access rather than dropping it
      S_ISSUE: if (!w_fetch_win) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_win         <= '0;
      r_fetch_d     <= 1'b0;
      r_disp_rdata  <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_d     <= w_fetch_win;
      r_frame_start <= (i_h_count == 16'd0) && (i_v_count == 16'd0);
      if (w_grant)
        r_win <= w_pick;
      if (r_state == S_RESP)
        r_rr_ptr <= f_wrap(32'(r_win) + 32'd1);
      if (r_fetch_d)
        r_disp_rdata <= i_mem_rdata;
    end
  end

  // Port mux: display by default; winner only while ISSUE sees no window.
  // The write strobe is gated by reset so an ISSUE cut short writes nothing.
  always_comb begin
    o_mem_addr  = i_disp_addr;
    o_mem_we    = 1'b0;
    o_mem_wdata = w_cli_wdata[r_win];
    if (!w_fetch_win && (r_state == S_ISSUE)) begin
      o_mem_addr = w_cli_addr[r_win];
      o_mem_we   = i_cli_we[r_win] & i_resetn;
    end
  end

  assign o_cli_ack     = (r_state == S_RESP) ? (NUM_CLIENTS'(1) << r_win) : '0;
  assign o_cli_rdata   = (r_state == S_RESP) ? i_mem_rdata : '0;
  assign o_disp_rdata  = r_disp_rdata;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: drives raster counters and client
// requests, models the VRAM as a synchronous RAM, and checks acks, data,
// write strobes and display alignment against hand-computed values.
module tb_vram_port_arbiter;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 12;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [15:0]       h_count = 16'd0;
  logic [15:0]       v_count = 16'd10;
  logic [AW-1:0]     disp_addr = '0;
  logic [DW-1:0]     disp_rdata;
  logic [NC-1:0]     cli_req = '0;
  logic [NC-1:0]     cli_we = '0;
  logic [NC-1:0]     cli_ack;
  logic [AW-1:0]     caddr [NC];
  logic [DW-1:0]     cwd [NC];
  logic [NC*AW-1:0]  cli_addr;
  logic [NC*DW-1:0]  cli_wdata;
  logic [DW-1:0]     cli_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              frame_start;

  logic [DW-1:0]     mem [0:65535];

  int n_chk = 0;
  int n_pass = 0;
  bit cnt_en = 1'b0;
  int we_cnt = 0;
  int we_h = -1;
  int win_ack_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    cli_addr  = '0;
    cli_wdata = '0;
    for (int i = 0; i < NC; i++) begin
      cli_addr[i*AW +: AW]  = caddr[i];
      cli_wdata[i*DW +: DW] = cwd[i];
    end
  end

  vram_port_arbiter #(
    .NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW),
    .H_ACT_START(144), .H_ACT_END(784), .V_ACT_START(35), .V_ACT_END(515)
  ) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_h_count(h_count), .i_v_count(v_count),
    .i_disp_addr(disp_addr), .o_disp_rdata(disp_rdata),
    .i_cli_req(cli_req), .i_cli_we(cli_we),
    .i_cli_addr(cli_addr), .i_cli_wdata(cli_wdata),
    .o_cli_ack(cli_ack), .o_cli_rdata(cli_rdata),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_frame_start(frame_start)
  );

  // VRAM model: synchronous read, write on strobe, single writer process
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0010] = 12'h111;
    mem[16'h0011] = 12'h222;
    mem[16'h0012] = 12'h333;
    mem[16'h0013] = 12'h444;
    mem[16'h0020] = 12'h2B2;
    mem[16'h0123] = 12'hABC;
    mem[16'h0124] = 12'h777;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  function automatic bit in_win();
    return (h_count >= 16'd143) && (h_count < 16'd783) &&
           (v_count >= 16'd35) && (v_count < 16'd515);
  endfunction

  // One clock: counters advance just after the edge, then outputs are sampled
  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_en) begin
      if (h_count == 16'd799) begin
        h_count = 16'd0;
        v_count = (v_count == 16'd524) ? 16'd0 : v_count + 16'd1;
      end else begin
        h_count = h_count + 16'd1;
      end
    end
    #1;
    if (mem_we) begin
      we_cnt++;
      we_h = int'(h_count);
    end
  endtask

  task automatic wait_ack(input int c, input int budget, output int cyc, output int h_at);
    cyc  = 0;
    h_at = -1;
    for (int n = 0; n < budget; n++) begin
      tick();
      cyc++;
      if (in_win() && cli_ack != '0) win_ack_bad++;
      if (cli_ack[c]) begin
        h_at = int'(h_count);
        return;
      end
    end
    cyc = -1;
  endtask

  task automatic settle();
    cli_req = '0;
    cli_we  = '0;
    tick();
    tick();
  endtask

  initial begin
    int cyc, hat, k, fs_cnt, fs_h, fs_v;
    for (int i = 0; i < NC; i++) begin
      caddr[i] = 16'h0010 + 16'(i);
      cwd[i]   = '0;
    end

    // Reset hold with every client requesting
    resetn  = 1'b0;
    cli_req = 4'hF;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rst_ack", 32'(cli_ack), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_disp", 32'(disp_rdata), 32'd0);
    end

    // Release: client 0 first at cycle 2, then 1,2,3,0 every 3 cycles
    resetn = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if ((c + 1) % 3 == 0) begin
        k = ((c + 1) / 3 - 1) % 4;
        chk("rr_ack", 32'(cli_ack), 32'(1 << k));
        chk("rr_rdata", 32'(cli_rdata), 32'(12'h111 * (k + 1)));
      end else begin
        chk("rr_gap", 32'(cli_ack), 32'd0);
      end
    end
    settle();

    // Write then read by client 2
    we_cnt    = 0;
    caddr[2]  = 16'h0040;
    cwd[2]    = 12'h5A5;
    cli_we[2] = 1'b1;
    cli_req[2] = 1'b1;
    wait_ack(2, 10, cyc, hat);
    chk("wr_lat", 32'(cyc), 32'd2);
    chk("wr_ack", 32'(cli_ack), 32'h4);
    cli_we[2] = 1'b0;
    wait_ack(2, 10, cyc, hat);
    chk("rd_lat", 32'(cyc), 32'd3);
    chk("rd_data", 32'(cli_rdata), 32'h5A5);
    chk("wr_pulses", 32'(we_cnt), 32'd1);
    settle();

    // Reset while a write is in ISSUE: no write, no ack
    caddr[1]   = 16'h0060;
    cwd[1]     = 12'h999;
    cli_we[1]  = 1'b1;
    cli_req[1] = 1'b1;
    tick();
    chk("iss_we", 32'(mem_we), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstiss_we", 32'(mem_we), 32'd0);
    tick();
    chk("rstiss_ack0", 32'(cli_ack), 32'd0);
    tick();
    chk("rstiss_ack1", 32'(cli_ack), 32'd0);
    chk("rstiss_mem", 32'(mem[16'h0060]), 32'd0);
    resetn = 1'b1;
    settle();

    // Display read alignment: word at addr(h=143) shows at h=145
    v_count   = 16'd35;
    h_count   = 16'd143;
    disp_addr = 16'h0123;
    #1;
    chk("fw_addr", 32'(mem_addr), 32'h123);
    chk("fw_we", 32'(mem_we), 32'd0);
    tick();
    h_count = 16'd144;
    disp_addr = 16'h0124;
    #1;
    chk("disp_early", 32'(disp_rdata), 32'd0);
    tick();
    h_count = 16'd145;
    disp_addr = 16'h0125;
    #1;
    chk("disp_align", 32'(disp_rdata), 32'hABC);
    tick();
    chk("disp_next", 32'(disp_rdata), 32'h777);

    // Display priority: client 1 waits out the window, acked at h=785
    caddr[1]    = 16'h0020;
    v_count     = 16'd100;
    h_count     = 16'd200;
    cnt_en      = 1'b1;
    win_ack_bad = 0;
    cli_req     = 4'b0010;
    wait_ack(1, 800, cyc, hat);
    chk("prio_h", 32'(hat), 32'd785);
    chk("prio_data", 32'(cli_rdata), 32'h2B2);
    chk("prio_inwin", 32'(win_ack_bad), 32'd0);
    settle();

    // Request at h=783 on an active line is issued at once
    v_count  = 16'd50;
    h_count  = 16'd783;
    cli_req  = 4'b1000;
    wait_ack(3, 10, cyc, hat);
    chk("end_lat", 32'(cyc), 32'd2);
    chk("end_h", 32'(hat), 32'd785);
    chk("end_data", 32'(cli_rdata), 32'h444);
    settle();

    // Grant latched at h=142 collides with the window, completes at 783
    caddr[3]  = 16'h0050;
    cwd[3]    = 12'h3C3;
    v_count   = 16'd40;
    h_count   = 16'd142;
    we_cnt    = 0;
    we_h      = -1;
    cli_we[3] = 1'b1;
    cli_req   = 4'b1000;
    wait_ack(3, 800, cyc, hat);
    chk("coll_h", 32'(hat), 32'd784);
    chk("coll_we_h", 32'(we_h), 32'd783);
    chk("coll_we_cnt", 32'(we_cnt), 32'd1);
    chk("coll_mem", 32'(mem[16'h0050]), 32'h3C3);
    settle();

    // ISSUE at h=142 completes before the window opens
    caddr[0]  = 16'h0070;
    cwd[0]    = 12'h0F0;
    v_count   = 16'd40;
    h_count   = 16'd141;
    we_cnt    = 0;
    we_h      = -1;
    cli_we[0] = 1'b1;
    cli_req   = 4'b0001;
    wait_ack(0, 10, cyc, hat);
    chk("pre_h", 32'(hat), 32'd143);
    chk("pre_we_h", 32'(we_h), 32'd142);
    chk("pre_mem", 32'(mem[16'h0070]), 32'h0F0);
    settle();

    // frame_start: one pulse, the cycle after (0,0)
    h_count = 16'd795;
    v_count = 16'd524;
    fs_cnt = 0;
    fs_h = -1;
    fs_v = -1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (frame_start) begin
        fs_cnt++;
        fs_h = int'(h_count);
        fs_v = int'(v_count);
      end
    end
    chk("fs_cnt", 32'(fs_cnt), 32'd1);
    chk("fs_h", 32'(fs_h), 32'd1);
    chk("fs_v", 32'(fs_v), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
